// File: rtl/dm_hart_handshake_ctrl.sv
// ----------------------------------------------------------------------------
// dm_hart_handshake_ctrl
//
// Debug-module side of the hart park-loop handshake. Each hart spinning in the
// debug ROM polls its flag byte at 0x400+hartid (bit0 = go, bit1 = resume) and
// reports progress by writing its hartid to one of the mailbox words:
//   0x100 HALTED, 0x104 GOING, 0x108 RESUMING, 0x10C EXCEPTION.
// This block owns those flag bytes, tracks halted/resumeack per hart, and runs
// a small abstract-command FSM (IDLE -> GO_WAIT -> EXEC -> IDLE).
//
// Handshake semantics: there is no valid/ready pair here. Every DM-side request
// (resumereq, cmd_go) is a single-cycle strobe that is either accepted on that
// cycle or dropped; the hart side is a plain write strobe (mem_wen) and read
// strobe (mem_ren) with read data returned exactly one cycle later.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   dmactive        low = synchronous clear of every register
//   hartsel         hart targeted by resumereq / cmd_go
//   haltreq         per-hart level halt request
//   resumereq       one-cycle resume request for hartsel
//   cmd_go          one-cycle abstract-command start for hartsel
//   mem_wen/waddr/wdata   hart-side mailbox write (wdata[HART_W-1:0] = hartid)
//   mem_ren/raddr   hart-side flag read
//   mem_rdata/rhit  registered read data / flag-region hit
//   debug_req       registered debug interrupt per hart
//   halted          hart parked in ROM
//   resumeack       sticky resume acknowledge
//   cmd_busy        command FSM not idle
//   cmd_done/cmd_exc/cmd_err_halt  one-cycle status pulses
//   dbg_state       current command FSM state (observability only)
// ----------------------------------------------------------------------------
module dm_hart_handshake_ctrl #(
  parameter int HART_NUM = 1,
  parameter int HART_W   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                dmactive,
  input  logic [HART_W-1:0]   hartsel,
  input  logic [HART_NUM-1:0] haltreq,
  input  logic                resumereq,
  input  logic                cmd_go,
  input  logic                mem_wen,
  input  logic [11:0]         mem_waddr,
  input  logic [31:0]         mem_wdata,
  input  logic                mem_ren,
  input  logic [11:0]         mem_raddr,
  output logic [31:0]         mem_rdata,
  output logic                mem_rhit,
  output logic [HART_NUM-1:0] debug_req,
  output logic [HART_NUM-1:0] halted,
  output logic [HART_NUM-1:0] resumeack,
  output logic                cmd_busy,
  output logic                cmd_done,
  output logic                cmd_exc,
  output logic                cmd_err_halt,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GO_WAIT = 2'd1,
    S_EXEC    = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [HART_NUM-1:0] r_go, r_resume, r_halted, r_ack, r_debug_req, r_cmd_oh;
  logic [HART_NUM-1:0] w_go_nxt, w_resume_nxt, w_halted_nxt, w_ack_nxt;
  logic [HART_NUM-1:0] w_wid_oh, w_sel_oh;
  logic [31:0]         r_rdata, w_flag_word;
  logic                r_rhit;
  logic                r_cmd_done, r_cmd_exc, r_cmd_err;
  logic                w_done_nxt, w_exc_nxt, w_err_nxt;
  logic                w_cmd_start, w_go_abort, w_res_acc;
  logic                w_sel_halted, w_from_cmd;
  logic                w_wr_halted, w_wr_going, w_wr_resuming, w_wr_exc;
  logic [HART_W-1:0]   w_wid;
  logic                w_unused;

  assign w_wid    = mem_wdata[HART_W-1:0];
  assign w_unused = ^mem_wdata[31:HART_W];

  // One-hot decode of the written hartid and of hartsel. An id at or above
  // HART_NUM decodes to all zeros, which is what makes such writes and
  // requests fall through as no-ops.
  always_comb begin
    w_wid_oh = '0;
    w_sel_oh = '0;
    for (int i = 0; i < HART_NUM; i++) begin
      w_wid_oh[i] = (w_wid == HART_W'(i));
      w_sel_oh[i] = (hartsel == HART_W'(i));
    end
  end

  assign w_sel_halted  = |(w_sel_oh & r_halted);
  assign w_from_cmd    = |(w_wid_oh & r_cmd_oh);
  assign w_wr_halted   = mem_wen && (mem_waddr == 12'h100) && (|w_wid_oh);
  assign w_wr_going    = mem_wen && (mem_waddr == 12'h104) && (|w_wid_oh);
  assign w_wr_resuming = mem_wen && (mem_waddr == 12'h108) && (|w_wid_oh);
  assign w_wr_exc      = mem_wen && (mem_waddr == 12'h10C) && (|w_wid_oh);

  // cmd_go takes priority: a resumereq in the same cycle is dropped even when
  // the command itself is rejected.
  assign w_res_acc = resumereq && !cmd_go && (r_state == S_IDLE) && w_sel_halted;

  // Command FSM: next state and pulse requests.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_exc_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_cmd_start = 1'b0;
    w_go_abort  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_go) begin
          if (w_sel_halted) begin
            w_cmd_start = 1'b1;
            w_state_nxt = S_GO_WAIT;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_GO_WAIT: begin
        if (w_wr_going && w_from_cmd) begin
          w_state_nxt = S_EXEC;
        end else if (w_wr_exc && w_from_cmd) begin
          // Hart faulted before picking up the go flag: retract it.
          w_go_abort  = 1'b1;
          w_exc_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_EXEC: begin
        if (w_wr_halted && w_from_cmd) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_wr_exc && w_from_cmd) begin
          w_exc_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Per-hart flag and status updates.
  always_comb begin
    w_go_nxt     = r_go;
    w_resume_nxt = r_resume;
    w_halted_nxt = r_halted;
    w_ack_nxt    = r_ack;
    if (w_cmd_start)   w_go_nxt = w_go_nxt | w_sel_oh;
    if (w_wr_going)    w_go_nxt = w_go_nxt & ~w_wid_oh;
    if (w_go_abort)    w_go_nxt = w_go_nxt & ~r_cmd_oh;
    if (w_res_acc) begin
      w_resume_nxt = w_resume_nxt | w_sel_oh;
      w_ack_nxt    = w_ack_nxt & ~w_sel_oh;
    end
    if (w_wr_resuming) begin
      w_halted_nxt = w_halted_nxt & ~w_wid_oh;
      w_resume_nxt = w_resume_nxt & ~w_wid_oh;
      w_ack_nxt    = w_ack_nxt | w_wid_oh;
    end
    if (w_wr_halted)   w_halted_nxt = w_halted_nxt | w_wid_oh;
  end

  // Flag word as currently stored; a read always sees pre-update values.
  always_comb begin
    w_flag_word = '0;
    for (int k = 0; k < HART_NUM; k++) begin
      w_flag_word[8*k +: 8] = {6'b0, r_resume[k], r_go[k]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (!dmactive) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_go        <= '0;
      r_resume    <= '0;
      r_halted    <= '0;
      r_ack       <= '0;
      r_debug_req <= '0;
      r_cmd_oh    <= '0;
      r_rdata     <= '0;
      r_rhit      <= 1'b0;
      r_cmd_done  <= 1'b0;
      r_cmd_exc   <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else if (!dmactive) begin
      r_go        <= '0;
      r_resume    <= '0;
      r_halted    <= '0;
      r_ack       <= '0;
      r_debug_req <= '0;
      r_cmd_oh    <= '0;
      r_rdata     <= '0;
      r_rhit      <= 1'b0;
      r_cmd_done  <= 1'b0;
      r_cmd_exc   <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_go        <= w_go_nxt;
      r_resume    <= w_resume_nxt;
      r_halted    <= w_halted_nxt;
      r_ack       <= w_ack_nxt;
      r_debug_req <= haltreq & ~r_halted;
      if (w_cmd_start) r_cmd_oh <= w_sel_oh;
      r_rhit      <= mem_ren && (mem_raddr == 12'h400);
      r_rdata     <= (mem_ren && (mem_raddr == 12'h400)) ? w_flag_word : 32'h0;
      r_cmd_done  <= w_done_nxt;
      r_cmd_exc   <= w_exc_nxt;
      r_cmd_err   <= w_err_nxt;
    end
  end

  assign mem_rdata    = r_rdata;
  assign mem_rhit     = r_rhit;
  assign debug_req    = r_debug_req;
  assign halted       = r_halted;
  assign resumeack    = r_ack;
  assign cmd_busy     = (r_state != S_IDLE);
  assign cmd_done     = r_cmd_done;
  assign cmd_exc      = r_cmd_exc;
  assign cmd_err_halt = r_cmd_err;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_dm_hart_handshake_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dm_hart_handshake_ctrl
//
// Two-hart instance. A directed sequence with literal expectations walks the
// halt / command / exception / resume / dmactive scenarios, then a randomized
// phase drives mixed requests and mailbox writes. A behavioural model tracks
// each hart's flags and the command phase; one compare process checks every
// DUT output against it on each falling edge.
// ----------------------------------------------------------------------------
module tb_dm_hart_handshake_ctrl;

  localparam int HN = 2;
  localparam int HW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dmactive = 1'b0;
  always #5 clk = ~clk;

  logic [HW-1:0] hartsel = '0;
  logic [HN-1:0] haltreq = '0;
  logic          resumereq = 1'b0;
  logic          cmd_go = 1'b0;
  logic          mem_wen = 1'b0;
  logic [11:0]   mem_waddr = '0;
  logic [31:0]   mem_wdata = '0;
  logic          mem_ren = 1'b0;
  logic [11:0]   mem_raddr = '0;

  logic [31:0]   mem_rdata;
  logic          mem_rhit;
  logic [HN-1:0] debug_req, halted, resumeack;
  logic          cmd_busy, cmd_done, cmd_exc, cmd_err_halt;
  logic [1:0]    dbg_state;

  dm_hart_handshake_ctrl #(.HART_NUM(HN), .HART_W(HW)) dut (
    .clk(clk), .rst_n(rst_n), .dmactive(dmactive),
    .hartsel(hartsel), .haltreq(haltreq), .resumereq(resumereq), .cmd_go(cmd_go),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .mem_rhit(mem_rhit),
    .debug_req(debug_req), .halted(halted), .resumeack(resumeack),
    .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cmd_exc(cmd_exc),
    .cmd_err_halt(cmd_err_halt), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Command phase: 0 = no command, 1 = waiting for the hart to report GOING,
  // 2 = hart executing the program buffer.
  logic [HN-1:0] m_halted = '0, m_go = '0, m_resume = '0, m_ack = '0, m_dreq = '0;
  int            m_phase = 0;
  int            m_cmd_hart = 0;
  logic          m_done = 1'b0, m_exc = 1'b0, m_err = 1'b0;
  logic          m_rv = 1'b0, m_rhit = 1'b0;
  logic [31:0]   m_rdata = '0;

  task automatic model_step();
    logic [HN-1:0] h0;
    int ph0, id, sel;
    if (!rst_n || !dmactive) begin
      m_halted = '0; m_go = '0; m_resume = '0; m_ack = '0; m_dreq = '0;
      m_phase = 0; m_done = 1'b0; m_exc = 1'b0; m_err = 1'b0;
      m_rv = 1'b0; m_rhit = 1'b0; m_rdata = '0;
    end else begin
      h0  = m_halted;
      ph0 = m_phase;
      id  = int'(mem_wdata[HW-1:0]);
      sel = int'(hartsel);
      m_done = 1'b0; m_exc = 1'b0; m_err = 1'b0;
      // read sees the flags as they were before this cycle's updates
      m_rv    = mem_ren;
      m_rhit  = mem_ren && (mem_raddr == 12'h400);
      m_rdata = '0;
      if (m_rhit)
        for (int k = 0; k < HN; k++)
          m_rdata = m_rdata | (32'({m_resume[k], m_go[k]}) << (8 * k));
      m_dreq = haltreq & ~h0;
      if (cmd_go) begin
        if (ph0 == 0) begin
          if (sel < HN && h0[sel]) begin
            m_phase = 1; m_cmd_hart = sel; m_go[sel] = 1'b1;
          end else begin
            m_err = 1'b1;
          end
        end
      end else if (resumereq && ph0 == 0 && sel < HN && h0[sel]) begin
        m_resume[sel] = 1'b1;
        m_ack[sel]    = 1'b0;
      end
      if (mem_wen && id < HN) begin
        case (mem_waddr)
          12'h100: begin
            m_halted[id] = 1'b1;
            if (ph0 == 2 && id == m_cmd_hart) begin m_phase = 0; m_done = 1'b1; end
          end
          12'h104: begin
            m_go[id] = 1'b0;
            if (ph0 == 1 && id == m_cmd_hart) m_phase = 2;
          end
          12'h108: begin
            m_halted[id] = 1'b0; m_resume[id] = 1'b0; m_ack[id] = 1'b1;
          end
          12'h10C: begin
            if ((ph0 == 1 || ph0 == 2) && id == m_cmd_hart) begin
              m_phase = 0; m_exc = 1'b1;
              if (ph0 == 1) m_go[id] = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- compare process ----------------
  initial forever begin
    @(negedge clk);
    check("debug_req", 32'(debug_req), 32'(m_dreq));
    check("halted", 32'(halted), 32'(m_halted));
    check("resumeack", 32'(resumeack), 32'(m_ack));
    check("cmd_busy", 32'(cmd_busy), 32'(m_phase != 0));
    check("cmd_done", 32'(cmd_done), 32'(m_done));
    check("cmd_exc", 32'(cmd_exc), 32'(m_exc));
    check("cmd_err_halt", 32'(cmd_err_halt), 32'(m_err));
    if (m_rv) begin
      check("mem_rhit", 32'(mem_rhit), 32'(m_rhit));
      check("mem_rdata", mem_rdata, m_rdata);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cmd_go = 1'b0; resumereq = 1'b0; mem_wen = 1'b0; mem_ren = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    mem_wen = 1'b1; mem_waddr = a; mem_wdata = d;
    tick();
  endtask

  task automatic rd_flags();
    mem_ren = 1'b1; mem_raddr = 12'h400;
    tick();
  endtask

  task automatic go(input int s);
    hartsel = HW'(s); cmd_go = 1'b1;
    tick();
  endtask

  task automatic rr(input int s);
    hartsel = HW'(s); resumereq = 1'b1;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a;
    repeat (2) @(negedge clk);
    check("rst_debug_req", 32'(debug_req), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_busy", 32'(cmd_busy), 32'h0);
    check("rst_rdata", mem_rdata, 32'h0);
    rst_n = 1'b1; dmactive = 1'b1;

    // halt request and HALTED mailbox
    haltreq = 2'b01;
    tick();                      check("lit_dreq_on", 32'(debug_req), 32'h1);
    wr(12'h100, 32'd0);          check("lit_halted0", 32'(halted), 32'h1);
    tick();                      check("lit_dreq_off", 32'(debug_req), 32'h0);

    // clean command
    go(0);                       check("lit_busy", 32'(cmd_busy), 32'h1);
    rd_flags();                  check("lit_go_flag", mem_rdata, 32'h1);
                                 check("lit_rhit", 32'(mem_rhit), 32'h1);
    wr(12'h104, 32'd0);
    rd_flags();                  check("lit_go_clr", mem_rdata, 32'h0);
    wr(12'h100, 32'd0);          check("lit_done", 32'(cmd_done), 32'h1);
                                 check("lit_busy_off", 32'(cmd_busy), 32'h0);
    tick();                      check("lit_done_1cyc", 32'(cmd_done), 32'h0);

    // exception during EXEC
    go(0);
    wr(12'h104, 32'd0);
    wr(12'h10C, 32'd0);          check("lit_exc", 32'(cmd_exc), 32'h1);
                                 check("lit_exc_halted", 32'(halted), 32'h1);

    // resume flow
    rr(0);
    rd_flags();                  check("lit_resume_flag", mem_rdata, 32'h2);
    wr(12'h108, 32'd0);          check("lit_resumed", 32'(halted), 32'h0);
                                 check("lit_ack", 32'(resumeack), 32'h1);
    wr(12'h100, 32'd0);
    rr(0);                       check("lit_ack_clr", 32'(resumeack), 32'h0);

    // command to a running hart, then cmd_go + resumereq together
    wr(12'h108, 32'd0);
    go(0);                       check("lit_err_halt", 32'(cmd_err_halt), 32'h1);
                                 check("lit_err_busy", 32'(cmd_busy), 32'h0);
    wr(12'h100, 32'd0);
    hartsel = '0; cmd_go = 1'b1; resumereq = 1'b1;
    tick();
    rd_flags();                  check("lit_go_wins", mem_rdata, 32'h1);
    wr(12'h104, 32'd0);
    wr(12'h100, 32'd0);

    // out-of-range hartid, second hart, dmactive drop mid-command
    wr(12'h100, 32'd3);          check("lit_bad_id", 32'(halted), 32'h1);
    wr(12'h100, 32'd1);          check("lit_two_halted", 32'(halted), 32'h3);
    rr(1);
    rd_flags();                  check("lit_lane1", mem_rdata, 32'h200);
    go(1);
    wr(12'h104, 32'd1);
    dmactive = 1'b0;
    tick();                      check("lit_clr_busy", 32'(cmd_busy), 32'h0);
                                 check("lit_clr_halted", 32'(halted), 32'h0);
                                 check("lit_clr_ack", 32'(resumeack), 32'h0);
    dmactive = 1'b1;
    haltreq = '0;
    tick();

    // randomized phase
    for (int c = 0; c < 3000; c++) begin
      a = $urandom_range(0, 19);
      hartsel = HW'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) haltreq = HN'($urandom_range(0, 3));
      if (a == 0) cmd_go = 1'b1;
      else if (a <= 2) resumereq = 1'b1;
      else if (a == 3) begin cmd_go = 1'b1; resumereq = 1'b1; end
      else if (a < 12) begin
        mem_wen = 1'b1;
        case ($urandom_range(0, 4))
          0: mem_waddr = 12'h100;
          1: mem_waddr = 12'h104;
          2: mem_waddr = 12'h108;
          3: mem_waddr = 12'h10C;
          default: mem_waddr = 12'h200;
        endcase
        mem_wdata = $urandom();
        mem_wdata[1:0] = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 1) == 1) begin
        mem_ren = 1'b1;
        mem_raddr = ($urandom_range(0, 4) != 0) ? 12'h400 : 12'($urandom_range(0, 1023) * 4);
      end
      dmactive = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_hart_handshake_ctrl.md
Name: dm_hart_handshake_ctrl

Overview:
- Debug-module controller that sequences harts through the debug ROM / program-buffer park loop.
- Owns the per-hart flag bytes the ROM polls at 0x400+hartid (bit0 = go, bit1 = resume).
- Decodes the ROM's mailbox writes: HALTED 0x100, GOING 0x104, RESUMING 0x108, EXCEPTION 0x10C; write data = hartid.
- Turns DM-side requests (haltreq, resumereq, abstract-command go) into hart flags and reports halt/resume/command status back to the DM register block.

Parameters:
HART_NUM, 1, number of harts served (1..4).
HART_W, 2, hartid/hartsel width; HART_NUM <= 2**HART_W.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
dmactive  input  1  low = synchronous clear of all state to reset values
hartsel  input  HART_W  hart targeted by resumereq / cmd_go
haltreq  input  HART_NUM  level halt request per hart
resumereq  input  1  one-cycle resume request for hartsel
cmd_go  input  1  one-cycle abstract-command start for hartsel
mem_wen  input  1  debug-memory write strobe (hart side)
mem_waddr  input  12  word-aligned debug-memory byte offset
mem_wdata  input  32  write data; [HART_W-1:0] = hartid
mem_ren  input  1  debug-memory read strobe
mem_raddr  input  12  read byte offset
mem_rdata  output  32  flag word; valid the cycle after mem_ren
mem_rhit  output  1  read hit flag region; registered with mem_rdata
debug_req  output  HART_NUM  debug interrupt to each core
halted  output  HART_NUM  hart parked in ROM
resumeack  output  HART_NUM  sticky resume acknowledge
cmd_busy  output  1  abstract command in progress
cmd_done  output  1  one-cycle pulse, command completed cleanly
cmd_exc  output  1  one-cycle pulse, command raised exception
cmd_err_halt  output  1  one-cycle pulse, cmd_go rejected (hart not halted)

Behaviour:
- Reset (rst_n low, async) and dmactive low (sync): all outputs 0, all flags 0, command FSM in IDLE.
- debug_req[i] = haltreq[i] & ~halted[i], registered (1-cycle latency).
- Writes apply only when mem_wen and hartid < HART_NUM; others are ignored.
- HALTED write: halted[id] <= 1 next cycle; the go/resume flags for id are unchanged.
- RESUMING write: halted[id] <= 0, resume flag[id] <= 0, resumeack[id] <= 1.
- GOING write: go flag[id] <= 0.
- Flag read: 0x400 hits; mem_rdata byte lane k = {6'b0, resume[k], go[k]} for k < HART_NUM; other lanes 0. Any other address: mem_rhit 0, mem_rdata 0.
- resumereq accepted only when halted[hartsel] and FSM IDLE. It sets resume flag[hartsel] and clears resumeack[hartsel] next cycle. Otherwise it is dropped silently.
- Command FSM (tracks cmd_hart latched at cmd_go):
  - IDLE: cmd_go with halted[hartsel] -> GO_WAIT, go flag set, cmd_busy 1. cmd_go with hart not halted -> cmd_err_halt pulse, stay IDLE.
  - GO_WAIT: GOING write from cmd_hart -> EXEC.
  - EXEC: HALTED write from cmd_hart -> IDLE, cmd_done pulse. EXCEPTION write from cmd_hart -> IDLE, cmd_exc pulse, halted stays 1.
  - EXCEPTION write in GO_WAIT -> IDLE, cmd_exc pulse, go flag cleared.
  - Mailbox writes from other harts: update halted/resumeack only; FSM unaffected.
- cmd_busy is low in IDLE and high in GO_WAIT and EXEC. All pulses are registered and last exactly one cycle.
- Simultaneous cmd_go and resumereq: cmd_go wins; resumereq is dropped.
- Simultaneous flag read and flag update: the read returns the pre-update value.
- dmactive falling mid-command: FSM returns to IDLE, flags clear, no pulse.

Test Plan:
- Reset, then haltreq[0]=1 -> debug_req[0]=1 one cycle later. Write 0x100 data 0 -> halted[0]=1, debug_req[0]=0.
- Hart 0 halted, cmd_go, hartsel=0 -> cmd_busy=1; read 0x400 gives 0x00000001. Write 0x104 -> flag cleared. Write 0x100 -> cmd_done pulse, cmd_busy=0.
- Command in EXEC, write 0x10C data 0 -> cmd_exc pulse, halted[0] stays 1, FSM IDLE.
- Hart halted, resumereq -> read 0x400 gives 0x00000002. Write 0x108 -> halted=0, resumeack=1; a new resumereq clears resumeack.
- cmd_go while halted[0]=0 -> cmd_err_halt pulse, cmd_busy stays 0. cmd_go and resumereq in the same cycle -> only go flag set.
- HART_NUM=2: write 0x100 data 3 -> ignored. Hart 1 halted, flags read -> byte 1 reflects hart 1. Drop dmactive in EXEC -> all outputs 0.
